// File: rtl/mem_responder.sv
// Purpose : single-port word memory that answers load/store requests after a
//           fixed number of wait states and optionally judges a pass/fail test.
// Latency : MemReady is seen WAIT_CYCLES+1 cycles after the request is sampled;
//           a held MemReq restarts every WAIT_CYCLES+2 cycles.
// Backpressure: none to the initiator; it holds MemReq and the request fields
//           until MemReady. Fields are captured, so later changes are ignored.
//
// Ports
//   CLK        rising-edge clock
//   Reset      asynchronous, active-high reset (storage is not cleared)
//   MemReq     request valid
//   MemWrite   1 = store, 0 = load
//   DataAdr    byte address; bits [1:0] ignored, wraps at DEPTH_WORDS*4
//   WriteData  store data
//   ByteEn     per-byte store enables
//   ReadData   load data during the response cycle, 0 otherwise
//   MemReady   one-cycle response strobe
//   Done/Pass  sticky test verdict
//
// Build option: define MEM_RESP_MONITOR_EN to include the pass/fail monitor.
// Without it Done and Pass are tied to 0.

module mem_responder #(
   parameter int          DEPTH_WORDS = 64,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] PASS_ADR    = 32'd84,
   parameter logic [31:0] PASS_DATA   = 32'd71,
   parameter logic [31:0] ALLOW_ADR   = 32'd80
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        MemReq,
   input  logic        MemWrite,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   input  logic [3:0]  ByteEn,
   output logic [31:0] ReadData,
   output logic        MemReady,
   output logic        Done,
   output logic        Pass
);

   localparam int         AW      = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  cnt;
   logic [3:0]  cnt_nxt;
   logic        capture;
   logic        resp;

   // Captured request; the low two address bits never matter, so they are
   // not stored.
   logic [31:2] cap_adr;
   logic [31:0] cap_dat;
   logic [3:0]  cap_be;
   logic        cap_wr;

   logic [31:0] mem [DEPTH_WORDS];
   logic [AW-1:0] word_idx;
   logic        commit;

   logic        unused_adr_lsb;
   assign unused_adr_lsb = ^DataAdr[1:0];

   // ------------------------------------------------------------------
   // State register and request capture
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         cap_adr <= '0;
         cap_dat <= '0;
         cap_be  <= '0;
         cap_wr  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (capture) begin
            cap_adr <= DataAdr[31:2];
            cap_dat <= WriteData;
            cap_be  <= ByteEn;
            cap_wr  <= MemWrite;
         end
      end
   end

   // ------------------------------------------------------------------
   // Next state and response strobe
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      capture   = 1'b0;
      resp      = 1'b0;
      case (state)
         IDLE: begin
            if (MemReq) begin
               capture = 1'b1;
               cnt_nxt = WAIT_LD;
               state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            // Leave on the edge where the counter goes 1 -> 0. A zero
            // count here cannot occur normally; exit rather than wrap.
            if (cnt <= 4'd1) begin
               cnt_nxt   = 4'd0;
               state_nxt = RESP;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         RESP: begin
            resp      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
         end
      endcase
   end

   assign MemReady = resp;
   assign word_idx = cap_adr[AW+1:2];

   // A store lands on the edge that ends RESP. An asserted Reset has already
   // forced the state to IDLE, so an aborted request never writes.
   assign commit = resp && cap_wr;

   // ------------------------------------------------------------------
   // Storage: byte-lane writes, no reset
   // ------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (commit) begin
         for (int i = 0; i < 4; i++) begin
            if (cap_be[i]) begin
               mem[word_idx][8*i +: 8] <= cap_dat[8*i +: 8];
            end
         end
      end
   end

   assign ReadData = (resp && !cap_wr) ? mem[word_idx] : 32'd0;

   // ------------------------------------------------------------------
   // Pass/fail monitor
   // ------------------------------------------------------------------
`ifdef MEM_RESP_MONITOR_EN
   logic done_q;
   logic pass_q;
   logic hit_pass;
   logic hit_allow;

   assign hit_pass  = (cap_adr == PASS_ADR[31:2]) && (cap_dat == PASS_DATA);
   assign hit_allow = (cap_adr == ALLOW_ADR[31:2]);

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         done_q <= 1'b0;
         pass_q <= 1'b0;
      end else if (commit && !done_q) begin
         // Verdict is frozen once reached; later stores only hit memory.
         if (hit_pass) begin
            done_q <= 1'b1;
            pass_q <= 1'b1;
         end else if (!hit_allow) begin
            done_q <= 1'b1;
            pass_q <= 1'b0;
         end
      end
   end

   assign Done = done_q;
   assign Pass = pass_q;
`else
   logic unused_mon;
   assign unused_mon = ^{cap_adr[31:AW+2]};
   assign Done = 1'b0;
   assign Pass = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

   localparam int WAITS = 2;
`ifdef MEM_RESP_MONITOR_EN
   localparam logic MON = 1'b1;
`else
   localparam logic MON = 1'b0;
`endif

   logic        CLK;
   logic        Reset;
   logic        MemReq;
   logic        MemWrite;
   logic [31:0] DataAdr;
   logic [31:0] WriteData;
   logic [3:0]  ByteEn;
   logic [31:0] ReadData;
   logic        MemReady;
   logic        Done;
   logic        Pass;

   int errors = 0;
   int checks = 0;

   mem_responder #(
      .DEPTH_WORDS(64),
      .WAIT_CYCLES(WAITS),
      .PASS_ADR   (32'd84),
      .PASS_DATA  (32'd71),
      .ALLOW_ADR  (32'd80)
   ) dut (
      .CLK      (CLK),
      .Reset    (Reset),
      .MemReq   (MemReq),
      .MemWrite (MemWrite),
      .DataAdr  (DataAdr),
      .WriteData(WriteData),
      .ByteEn   (ByteEn),
      .ReadData (ReadData),
      .MemReady (MemReady),
      .Done     (Done),
      .Pass     (Pass)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Issue one request and hold it until MemReady. lat counts the edge on
   // which MemReady is seen, relative to the sampling edge. Returns #1 after
   // the edge that ends the response (store already committed).
   task automatic do_req(input logic wr, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] be,
                         output logic [31:0] rdata, output int lat);
      MemReq = 1'b1; MemWrite = wr; DataAdr = adr; WriteData = dat; ByteEn = be;
      @(posedge CLK); #1;
      lat = 1;
      while (MemReady !== 1'b1 && lat < 40) begin
         @(posedge CLK); #1;
         lat++;
      end
      rdata = ReadData;
      if (MemReady !== 1'b1) begin
         checks++; errors++;
         $display("FAIL req_timeout adr=%h: no MemReady within %0d cycles", adr, lat);
      end
      MemReq = 1'b0; MemWrite = 1'b0;
      @(posedge CLK); #1;
   endtask

   task automatic pulse_reset();
      Reset = 1'b1;
      @(posedge CLK); #1;
      Reset = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1; MemReq = 1'b0; MemWrite = 1'b0;
      DataAdr = '0; WriteData = '0; ByteEn = '0;
      repeat (2) @(posedge CLK);
      #1;
      checks++;
      if ({MemReady, ReadData, Done, Pass} !== 35'd0) begin
         errors++;
         $display("FAIL reset_hold: rdy=%b rd=%h done=%b pass=%b, all should be 0",
                  MemReady, ReadData, Done, Pass);
      end
      Reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge CLK); #1;
         checks++;
         if ({MemReady, ReadData, Done, Pass} !== 35'd0) begin
            errors++;
            $display("FAIL reset_idle cyc %0d: rdy=%b rd=%h done=%b pass=%b, all should be 0",
                     i, MemReady, ReadData, Done, Pass);
         end
      end
   endtask

   task automatic test_basic();
      logic [31:0] rd;
      int lat;
      do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, rd, lat);
      checks++;
      if (lat !== WAITS + 1) begin
         errors++; $display("FAIL store_latency: got %0d want %0d", lat, WAITS + 1);
      end
      do_req(1'b0, 32'h10, 32'h0, 4'b0000, rd, lat);
      checks++;
      if (lat !== WAITS + 1) begin
         errors++; $display("FAIL load_latency: got %0d want %0d", lat, WAITS + 1);
      end
      checks++;
      if (rd !== 32'hDEADBEEF) begin
         errors++; $display("FAIL load_data: got %h want deadbeef", rd);
      end
      checks++;
      if (ReadData !== 32'd0) begin
         errors++; $display("FAIL rdata_idle: got %h want 00000000", ReadData);
      end
      // Low address bits are ignored.
      do_req(1'b0, 32'h13, 32'h0, 4'b0000, rd, lat);
      checks++;
      if (rd !== 32'hDEADBEEF) begin
         errors++; $display("FAIL load_lowbits: got %h want deadbeef", rd);
      end
   endtask

   task automatic test_byte_en();
      logic [31:0] rd;
      int lat;
      do_req(1'b1, 32'h30, 32'h11223344, 4'b1111, rd, lat);
      do_req(1'b1, 32'h30, 32'hAABBCCDD, 4'b0101, rd, lat);
      do_req(1'b0, 32'h30, 32'h0, 4'b0000, rd, lat);
      checks++;
      if (rd !== 32'h11BB33DD) begin
         errors++; $display("FAIL byte_en_0101: got %h want 11bb33dd", rd);
      end
      do_req(1'b1, 32'h30, 32'hFFFFFFFF, 4'b0000, rd, lat);
      checks++;
      if (lat !== WAITS + 1) begin
         errors++; $display("FAIL byte_en_0000_resp: latency %0d want %0d", lat, WAITS + 1);
      end
      do_req(1'b0, 32'h30, 32'h0, 4'b0000, rd, lat);
      checks++;
      if (rd !== 32'h11BB33DD) begin
         errors++; $display("FAIL byte_en_0000: got %h want 11bb33dd", rd);
      end
   endtask

   task automatic test_capture();
      logic [31:0] rd;
      int lat;
      int n;
      MemReq = 1'b1; MemWrite = 1'b1; DataAdr = 32'h40;
      WriteData = 32'hCAFEF00D; ByteEn = 4'b1111;
      @(posedge CLK); #1;
      // Scramble the fields after capture; the captured copy must win.
      MemWrite = 1'b0; DataAdr = 32'h44; WriteData = 32'h0BADBAD0; ByteEn = 4'b0000;
      n = 0;
      while (MemReady !== 1'b1 && n < 40) begin
         @(posedge CLK); #1;
         n++;
      end
      checks++;
      if (MemReady !== 1'b1) begin
         errors++; $display("FAIL capture_resp: MemReady=%b want 1", MemReady);
      end
      MemReq = 1'b0;
      @(posedge CLK); #1;
      do_req(1'b0, 32'h40, 32'h0, 4'b0000, rd, lat);
      checks++;
      if (rd !== 32'hCAFEF00D) begin
         errors++; $display("FAIL capture_data: got %h want cafef00d", rd);
      end
      do_req(1'b0, 32'h44, 32'h0, 4'b0000, rd, lat);
      checks++;
      if (rd !== 32'h0) begin
         errors++; $display("FAIL capture_adr: word 0x44 got %h want 00000000", rd);
      end
   endtask

   task automatic test_back_to_back();
      int pulse [3];
      int n;
      n = 0;
      MemReq = 1'b1; MemWrite = 1'b0; DataAdr = 32'h10; ByteEn = 4'b0000;
      for (int i = 0; i < 30 && n < 3; i++) begin
         @(posedge CLK); #1;
         if (MemReady === 1'b1) begin
            pulse[n] = i;
            n++;
            checks++;
            if (ReadData !== 32'hDEADBEEF) begin
               errors++; $display("FAIL b2b_data pulse %0d: got %h want deadbeef", n, ReadData);
            end
         end else begin
            checks++;
            if (ReadData !== 32'd0) begin
               errors++; $display("FAIL b2b_rdata_zero cyc %0d: got %h want 0", i, ReadData);
            end
         end
      end
      MemReq = 1'b0;
      @(posedge CLK); #1;
      checks++;
      if (n !== 3) begin
         errors++; $display("FAIL b2b_count: got %0d pulses want 3", n);
      end else begin
         checks++;
         if (pulse[1] - pulse[0] !== WAITS + 2 || pulse[2] - pulse[1] !== WAITS + 2) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d,%0d want %0d", pulse[1] - pulse[0],
                     pulse[2] - pulse[1], WAITS + 2);
         end
      end
   endtask

   task automatic test_monitor_pass();
      logic [31:0] rd;
      int lat;
      pulse_reset();
      do_req(1'b1, 32'd80, 32'd71, 4'b1111, rd, lat);
      checks++;
      if (Done !== 1'b0) begin
         errors++; $display("FAIL mon_allow_done: got %b want 0", Done);
      end
      do_req(1'b1, 32'd84, 32'd71, 4'b1111, rd, lat);
      checks++;
      if (Done !== MON || Pass !== MON) begin
         errors++; $display("FAIL mon_pass: done=%b pass=%b want %b %b", Done, Pass, MON, MON);
      end
      do_req(1'b1, 32'd8, 32'd5, 4'b1111, rd, lat);
      checks++;
      if (Done !== MON || Pass !== MON) begin
         errors++; $display("FAIL mon_frozen: done=%b pass=%b want %b %b", Done, Pass, MON, MON);
      end
      do_req(1'b0, 32'd8, 32'd0, 4'b0000, rd, lat);
      checks++;
      if (rd !== 32'd5) begin
         errors++; $display("FAIL mon_still_serviced: got %h want 00000005", rd);
      end
   endtask

   task automatic test_monitor_fail();
      logic [31:0] rd;
      int lat;
      pulse_reset();
      checks++;
      if (Done !== 1'b0 || Pass !== 1'b0) begin
         errors++; $display("FAIL mon_reset_clear: done=%b pass=%b want 0 0", Done, Pass);
      end
      do_req(1'b1, 32'd12, 32'd3, 4'b1111, rd, lat);
      checks++;
      if (Done !== MON || Pass !== 1'b0) begin
         errors++; $display("FAIL mon_fail: done=%b pass=%b want %b 0", Done, Pass, MON);
      end
      do_req(1'b1, 32'd84, 32'd71, 4'b1111, rd, lat);
      checks++;
      if (Done !== MON || Pass !== 1'b0) begin
         errors++; $display("FAIL mon_fail_frozen: done=%b pass=%b want %b 0", Done, Pass, MON);
      end
   endtask

   task automatic test_reset_abort();
      logic [31:0] rd;
      int lat;
      int seen;
      MemReq = 1'b1; MemWrite = 1'b1; DataAdr = 32'h20;
      WriteData = 32'h55; ByteEn = 4'b1111;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      Reset = 1'b1; MemReq = 1'b0; MemWrite = 1'b0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (i == 2) Reset = 1'b0;
         if (MemReady === 1'b1) seen++;
         @(posedge CLK); #1;
      end
      checks++;
      if (seen !== 0) begin
         errors++; $display("FAIL abort_no_ready: saw %0d pulses want 0", seen);
      end
      do_req(1'b0, 32'h20, 32'h0, 4'b0000, rd, lat);
      checks++;
      if (rd !== 32'h0) begin
         errors++; $display("FAIL abort_no_commit: got %h want 00000000", rd);
      end
      do_req(1'b1, 32'h120, 32'h77, 4'b1111, rd, lat);
      do_req(1'b0, 32'h20, 32'h0, 4'b0000, rd, lat);
      checks++;
      if (rd !== 32'h77) begin
         errors++; $display("FAIL alias_0x120: got %h want 00000077", rd);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_byte_en();
      test_capture();
      test_back_to_back();
      test_monitor_pass();
      test_monitor_fail();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
